// File: rtl/mat_vec_scheduler_pkg.sv
// mat_vec_pkg: shared types and helpers for the matrix-vector scheduler.
//
// Contents:
//   DEFAULT_DATA_W - default element / result width
//   word_t         - one element or scalar result
//   sched_state_t  - scheduler FSM states
//   relu()         - clamps negative (two's complement) values to zero; used
//                    only when MAT_VEC_SCHEDULER_RELU_EN is defined, and sized
//                    for DEFAULT_DATA_W-wide data
package mat_vec_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef logic [DEFAULT_DATA_W-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT,
    CAPTURE,
    DONE
  } sched_state_t;

  function automatic word_t relu(input word_t value);
    return value[DEFAULT_DATA_W-1] ? '0 : value;
  endfunction

endpackage

// File: rtl/mat_vec_scheduler_if.sv
// mat_vec_scheduler_if: bundles the layer-controller handshake and the
// dot-product engine connection of the scheduler.
//
// Signals:
//   start, mat, vec       - controller request and operands
//   busy, done, result    - scheduler status and output vector
//   dp_rst, dp_vec1/2     - engine reset and operands (from the scheduler)
//   dp_result, dp_done    - engine scalar result and level done (to the scheduler)
//
// Modports:
//   slave  - the scheduler itself
//   master - whatever sits around it (controller plus engine)
interface mat_vec_scheduler_if
  import mat_vec_pkg::*;
#(
  parameter int VECTOR_LEN = 4,
  parameter int ROWS       = 4,
  parameter int DATA_W     = DEFAULT_DATA_W
);

  logic                                       start;
  logic [ROWS-1:0][VECTOR_LEN-1:0][DATA_W-1:0] mat;
  logic [VECTOR_LEN-1:0][DATA_W-1:0]           vec;
  logic                                       busy;
  logic                                       done;
  logic [ROWS-1:0][DATA_W-1:0]                 result;
  logic                                       dp_rst;
  logic [VECTOR_LEN-1:0][DATA_W-1:0]           dp_vec1;
  logic [VECTOR_LEN-1:0][DATA_W-1:0]           dp_vec2;
  logic [DATA_W-1:0]                           dp_result;
  logic                                       dp_done;

  modport slave (
    input  start, mat, vec, dp_result, dp_done,
    output busy, done, result, dp_rst, dp_vec1, dp_vec2
  );

  modport master (
    output start, mat, vec, dp_result, dp_done,
    input  busy, done, result, dp_rst, dp_vec1, dp_vec2
  );

endinterface

// File: rtl/mat_vec_scheduler_row_counter.sv
// mvs_row_counter: row index for the scheduler.
//
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   clear    - load zero (start of a new matrix)
//   inc      - advance to the next row; saturates at ROWS-1
//   row      - current row index
//   last     - high while row == ROWS-1
module mvs_row_counter
  import mat_vec_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  assign last = (row == ROW_W'(ROWS - 1));

  // Increment is suppressed on the last row so the index can never point
  // past the matrix, even for non power-of-two row counts.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
    end else if (inc && !last) begin
      row <= row + 1'b1;
    end
  end

endmodule

// File: rtl/mat_vec_scheduler.sv
// mat_vec_scheduler: runs one external dot-product engine once per matrix row
// to compute y = W*x, collecting each scalar into an output vector register.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (aborts a run without a done pulse)
//   bus  - mat_vec_scheduler_if.slave: start/mat/vec in, busy/done/result out,
//          dp_rst/dp_vec1/dp_vec2 to the engine, dp_result/dp_done from it
//
// Build option:
//   MAT_VEC_SCHEDULER_RELU_EN - when defined, negative engine results are
//   stored as zero. Timing is the same either way.
module mat_vec_scheduler
  import mat_vec_pkg::*;
#(
  parameter int VECTOR_LEN = 4,
  parameter int ROWS       = 4,
  parameter int DATA_W     = DEFAULT_DATA_W
) (
  input logic                clk,
  input logic                rst,
  mat_vec_scheduler_if.slave bus
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  sched_state_t state;
  sched_state_t state_next;

  logic [ROWS-1:0][VECTOR_LEN-1:0][DATA_W-1:0] mat_q;
  logic [VECTOR_LEN-1:0][DATA_W-1:0]           vec_q;
  logic [ROWS-1:0][DATA_W-1:0]                 result_q;
  logic [ROW_W-1:0]                            row;
  logic                                       last_row;
  logic                                       accept;
  logic                                       capture;
  logic                                       row_inc;
  logic [DATA_W-1:0]                           capture_value;

  mvs_row_counter #(
    .ROWS  (ROWS),
    .ROW_W (ROW_W)
  ) u_row_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .inc   (row_inc),
    .row   (row),
    .last  (last_row)
  );

`ifdef MAT_VEC_SCHEDULER_RELU_EN
  assign capture_value = relu(bus.dp_result);
`else
  assign capture_value = bus.dp_result;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-state strobes. dp_done is only looked at in WAIT, so
  // a level left high by the previous run cannot skip a row; start outside
  // IDLE (including the DONE cycle) is simply dropped.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    row_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.dp_done) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        if (last_row) begin
          state_next = DONE;
        end else begin
          row_inc    = 1'b1;
          state_next = CLEAR;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand snapshots and the result vector. The engine only ever sees the
  // snapshots, so the controller may change mat/vec freely once accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      mat_q    <= '0;
      vec_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        mat_q <= bus.mat;
        vec_q <= bus.vec;
      end
      if (capture) begin
        result_q[row] <= capture_value;
      end
    end
  end

  // The engine is held in reset during our own reset as well as for the one
  // CLEAR cycle before each row, so an aborted run leaves it clean.
  assign bus.dp_rst  = rst | (state == CLEAR);
  assign bus.dp_vec1 = mat_q[row];
  assign bus.dp_vec2 = vec_q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.result  = result_q;

endmodule
